fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single frame-buffer BlockRAM write port between two pixel writers:
//  src0 = test-pattern generator, src1 = camera capture.
//  Each source pulses a write strobe with addr/data and gets no backpressure.
//  A small per-source FIFO absorbs collisions; a round-robin scheduler issues
//  at most one BRAM write per clk. Overflow is dropped, counted and flagged.
// PARAMETERS
//  ADDR_WIDTH  17  BRAM address width (76_800-word buffer)
//  DATA_WIDTH  12  pixel width {G,R,B} 4:4:4
//  FIFO_DEPTH  4   entries per source FIFO; power of 2, >=2
//  CNT_WIDTH   16  width of each drop counter
// PORTS
//  clk             in   1           system clock, all logic on rising edge
//  i_reset         in   1           asynchronous, active-high reset
//  i_enable        in   1           1 = scheduler may issue writes; 0 = hold FIFOs
//  i_src_en        in   2           per-source accept enable, bit n = src n
//  i_src0_write    in   1           src0 write strobe, one word per high cycle
//  i_src0_addr     in   ADDR_WIDTH  src0 write address
//  i_src0_data     in   DATA_WIDTH  src0 write data
//  i_src1_write    in   1           src1 write strobe
//  i_src1_addr     in   ADDR_WIDTH  src1 write address
//  i_src1_data     in   DATA_WIDTH  src1 write data
//  i_clear_flags   in   1           sync clear of overflow flags and drop counters
//  o_write         out  1           BRAM write enable (registered)
//  o_addr          out  ADDR_WIDTH  BRAM address (registered)
//  o_data          out  DATA_WIDTH  BRAM data (registered)
//  o_grant         out  2           one-hot source of current o_write word, 0 if idle
//  o_overflow      out  2           sticky per-source drop flag
//  o_src0_drops    out  CNT_WIDTH   src0 dropped-word count, saturating
//  o_src1_drops    out  CNT_WIDTH   src1 dropped-word count, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): FIFOs empty; o_write=0, o_addr=0, o_data=0,
//   o_grant=0, o_overflow=0, drop counters=0; RR pointer = src0 highest priority.
//  Push: at each edge where srcN_write && i_src_en[N], {addr,data} enters FIFO N.
//   If i_src_en[N]=0 the strobe is ignored: no push, no drop counted.
//  Full: if FIFO N is full and not popped the same edge, the word is dropped,
//   o_overflow[N] is set, and drops N increments, saturating at all-ones.
//   Full FIFO popped and pushed on the same edge: push accepted, no drop.
//  Schedule: on each edge with i_enable=1, choose one non-empty FIFO. If both
//   are non-empty, choose the one not granted last, then flip the pointer.
//   Chosen head pops into o_addr/o_data; o_write=1; o_grant=one-hot(N).
//   No candidate or i_enable=0: o_write=0, o_grant=0, o_addr/o_data hold.
//  Latency: strobe sampled at edge k into empty FIFO, no contention ->
//   o_write high for the cycle after edge k+1 (2 cycles). Per-source order kept.
//  Throughput: 1 word/clk total. Both sources strobing every clk -> alternating
//   grants; src words beyond FIFO_DEPTH backlog are dropped.
//  i_enable low: pushes continue, FIFOs fill, overflow rules apply; no writes.
//  i_clear_flags: clears o_overflow and counters at next edge. A drop on the same
//   edge wins: flag=1, count=1.
//  Reset mid-operation: queued words discarded, o_write drops to 0 immediately.
//  No address range check; addresses pass through unchanged.
// TESTING
//  1 src0 strobe addr=5 data=0xF00, src1 idle -> after 2 clk o_write=1,
//    o_addr=5, o_data=0xF00, o_grant=01, for one cycle only.
//  2 src0 and src1 strobe same edge (a=1/d=0xAAA, a=2/d=0x555) after reset ->
//    src0 written first, src1 next clk; o_grant 01 then 10.
//  3 i_enable=0, src1 strobes 6 words (FIFO_DEPTH=4) -> o_src1_drops=2,
//    o_overflow=10; after i_enable=1, words 0..3 are written in order.
//  4 Both sources strobe every clk for 100 clk -> o_grant alternates, 100 writes
//    each side minus counted drops; no reordering within a source.
//  5 Assert i_reset async with 3 words queued -> o_write=0 without waiting for
//    clk; after release, no stale writes.
//  6 i_clear_flags high on an edge with a src0 drop -> o_overflow[0]=1, drops0=1.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Lets two pixel writers share the single frame-buffer BRAM write port.
//   src0 is the test-pattern generator and src1 is the camera capture. Neither
//   source can be stalled, so each one writes into its own small FIFO. A
//   round-robin scheduler then issues at most one registered BRAM write per
//   clock. A word that arrives while its FIFO is full is dropped; the drop
//   sets a sticky flag and is counted.
//
// Ports
//   clk, i_reset             clock; asynchronous active-high reset
//   i_enable                 scheduler may issue writes (FIFOs keep filling when low)
//   i_src_en[1:0]            per-source accept enable
//   i_srcN_write/addr/data   per-source write strobe and word
//   i_clear_flags            synchronous clear of overflow flags and drop counters
//   o_write/o_addr/o_data    registered BRAM write port
//   o_grant[1:0]             one-hot source of the current o_write word
//   o_overflow[1:0]          sticky per-source drop flags
//   o_src0_drops/o_src1_drops  saturating drop counters
module fb_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [1:0]            i_src_en,
    input  logic                  i_src0_write,
    input  logic [ADDR_WIDTH-1:0] i_src0_addr,
    input  logic [DATA_WIDTH-1:0] i_src0_data,
    input  logic                  i_src1_write,
    input  logic [ADDR_WIDTH-1:0] i_src1_addr,
    input  logic [DATA_WIDTH-1:0] i_src1_data,
    input  logic                  i_clear_flags,
    output logic                  o_write,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_grant,
    output logic [1:0]            o_overflow,
    output logic [CNT_WIDTH-1:0]  o_src0_drops,
    output logic [CNT_WIDTH-1:0]  o_src1_drops
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    // FIFO storage is left without a reset; the pointers and counts define validity.
    logic [ENTRY_W-1:0] mem_q [2][FIFO_DEPTH];

    logic [1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0][PTR_W:0]       count_q, count_d;
    logic [1:0][CNT_WIDTH-1:0] drops_q, drops_d;
    logic [1:0]                overflow_q, overflow_d;
    logic                      prio_q, prio_d;  // 0: src0 preferred on contention
    logic                      write_q, write_d;
    logic [1:0]                grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    logic [1:0]              push_req, push, pop, drop, not_empty, full;
    logic [1:0][ENTRY_W-1:0] push_word, head;
    logic [ENTRY_W-1:0]      sel_word;

    always_comb begin
        push_req     = {i_src1_write & i_src_en[1], i_src0_write & i_src_en[0]};
        push_word[0] = {i_src0_addr, i_src0_data};
        push_word[1] = {i_src1_addr, i_src1_data};
        for (int n = 0; n < 2; n++) begin
            not_empty[n] = (count_q[n] != '0);
            full[n]      = (count_q[n] == (PTR_W + 1)'(FIFO_DEPTH));
            head[n]      = mem_q[n][rd_ptr_q[n]];
        end
    end

    // Round-robin pick: the pointer always favours the source that was not served last.
    always_comb begin
        pop = 2'b00;
        if (i_enable) begin
            if (not_empty[0] && not_empty[1]) begin
                pop = prio_q ? 2'b10 : 2'b01;
            end else if (not_empty[0]) begin
                pop = 2'b01;
            end else if (not_empty[1]) begin
                pop = 2'b10;
            end
        end
        prio_d = prio_q;
        if (pop[0]) begin
            prio_d = 1'b1;
        end else if (pop[1]) begin
            prio_d = 1'b0;
        end
    end

    // A full FIFO that is popped on the same edge still has room for the incoming word.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            push[n]     = push_req[n] & (~full[n] | pop[n]);
            drop[n]     = push_req[n] & full[n] & ~pop[n];
            wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + 1'b1 : wr_ptr_q[n];
            rd_ptr_d[n] = pop[n] ? rd_ptr_q[n] + 1'b1 : rd_ptr_q[n];
            count_d[n]  = count_q[n] + (PTR_W + 1)'(push[n]) - (PTR_W + 1)'(pop[n]);
        end
    end

    // On an edge with both a clear and a drop, the drop wins: the flag is set and the count is 1.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            overflow_d[n] = i_clear_flags ? 1'b0 : overflow_q[n];
            drops_d[n]    = i_clear_flags ? '0 : drops_q[n];
            if (drop[n]) begin
                overflow_d[n] = 1'b1;
                if (!(&drops_d[n])) begin
                    drops_d[n] = drops_d[n] + 1'b1;
                end
            end
        end
    end

    // When idle, the address and data registers keep their last value.
    always_comb begin
        sel_word = pop[1] ? head[1] : head[0];
        write_d  = |pop;
        grant_d  = pop;
        addr_d   = addr_q;
        data_d   = data_q;
        if (|pop) begin
            addr_d = sel_word[ENTRY_W-1:DATA_WIDTH];
            data_d = sel_word[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= push_word[n];
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drops_q    <= '0;
            overflow_q <= '0;
            prio_q     <= 1'b0;
            write_q    <= 1'b0;
            grant_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drops_q    <= drops_d;
            overflow_q <= overflow_d;
            prio_q     <= prio_d;
            write_q    <= write_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign o_write      = write_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_grant      = grant_q;
    assign o_overflow   = overflow_q;
    assign o_src0_drops = drops_q[0];
    assign o_src1_drops = drops_q[1];

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 12;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [1:0]    i_src_en;
    logic          i_src0_write;
    logic [AW-1:0] i_src0_addr;
    logic [DW-1:0] i_src0_data;
    logic          i_src1_write;
    logic [AW-1:0] i_src1_addr;
    logic [DW-1:0] i_src1_data;
    logic          i_clear_flags;
    logic          o_write;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [1:0]    o_grant;
    logic [1:0]    o_overflow;
    logic [CW-1:0] o_src0_drops;
    logic [CW-1:0] o_src1_drops;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_src_en     (i_src_en),
        .i_src0_write (i_src0_write),
        .i_src0_addr  (i_src0_addr),
        .i_src0_data  (i_src0_data),
        .i_src1_write (i_src1_write),
        .i_src1_addr  (i_src1_addr),
        .i_src1_data  (i_src1_data),
        .i_clear_flags(i_clear_flags),
        .o_write      (o_write),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_grant      (o_grant),
        .o_overflow   (o_overflow),
        .o_src0_drops (o_src0_drops),
        .o_src1_drops (o_src1_drops)
    );

    // Inputs change right after a falling edge; outputs are checked at falling edges.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_src0_write  = 1'b0;
        i_src1_write  = 1'b0;
        i_src0_addr   = '0;
        i_src0_data   = '0;
        i_src1_addr   = '0;
        i_src1_data   = '0;
        i_clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        idle_inputs();
        tick();
        i_reset  = 1'b0;
        i_enable = 1'b1;
        i_src_en = 2'b11;
    endtask

    task automatic test_reset();
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_src_en = 2'b11;
        idle_inputs();
        repeat (2) tick();
        n_vec++;
        if ({o_write, o_grant, o_overflow} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b expected 00000", {o_write, o_grant, o_overflow});
            n_err++;
        end
        n_vec++;
        if ({o_addr, o_data, o_src0_drops, o_src1_drops} !== '0) begin
            $display("FAIL reset_data: got addr=%h data=%h d0=%0d d1=%0d expected all 0",
                     o_addr, o_data, o_src0_drops, o_src1_drops);
            n_err++;
        end
        i_reset = 1'b0;
    endtask

    task automatic test_single();
        i_src0_write = 1'b1;
        i_src0_addr  = 17'd5;
        i_src0_data  = 12'hF00;
        tick();
        i_src0_write = 1'b0;
        n_vec++;
        if (o_write !== 1'b0) begin
            $display("FAIL single_early: got o_write=%b expected 0", o_write);
            n_err++;
        end
        tick();
        n_vec++;
        if ({o_write, o_grant, o_addr, o_data} !== {1'b1, 2'b01, 17'd5, 12'hF00}) begin
            $display("FAIL single_write: got w=%b g=%b a=%0d d=%h expected w=1 g=01 a=5 d=f00",
                     o_write, o_grant, o_addr, o_data);
            n_err++;
        end
        tick();
        n_vec++;
        if ({o_write, o_grant, o_addr} !== {1'b0, 2'b00, 17'd5}) begin
            $display("FAIL single_after: got w=%b g=%b a=%0d expected w=0 g=00 a=5",
                     o_write, o_grant, o_addr);
            n_err++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_src0_write = 1'b1;
        i_src0_addr  = 17'd1;
        i_src0_data  = 12'hAAA;
        i_src1_write = 1'b1;
        i_src1_addr  = 17'd2;
        i_src1_data  = 12'h555;
        tick();
        idle_inputs();
        tick();
        n_vec++;
        if ({o_write, o_grant, o_addr, o_data} !== {1'b1, 2'b01, 17'd1, 12'hAAA}) begin
            $display("FAIL simul_first: got w=%b g=%b a=%0d d=%h expected w=1 g=01 a=1 d=aaa",
                     o_write, o_grant, o_addr, o_data);
            n_err++;
        end
        tick();
        n_vec++;
        if ({o_write, o_grant, o_addr, o_data} !== {1'b1, 2'b10, 17'd2, 12'h555}) begin
            $display("FAIL simul_second: got w=%b g=%b a=%0d d=%h expected w=1 g=10 a=2 d=555",
                     o_write, o_grant, o_addr, o_data);
            n_err++;
        end
        tick();
        n_vec++;
        if (o_write !== 1'b0) begin
            $display("FAIL simul_idle: got o_write=%b expected 0", o_write);
            n_err++;
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_src1_write = 1'b1;
            i_src1_addr  = AW'(100 + i);
            i_src1_data  = DW'(12'h100 + i);
            tick();
        end
        idle_inputs();
        tick();
        n_vec++;
        if ({o_write, o_overflow, o_src1_drops, o_src0_drops} !== {1'b0, 2'b10, 16'd2, 16'd0})
        begin
            $display("FAIL hold_drops: got w=%b ovf=%b d1=%0d d0=%0d expected w=0 ovf=10 d1=2 d0=0",
                     o_write, o_overflow, o_src1_drops, o_src0_drops);
            n_err++;
        end
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({o_write, o_grant, o_addr, o_data} !== {1'b1, 2'b10, AW'(100 + i), DW'(12'h100 + i)})
            begin
                $display("FAIL hold_drain%0d: got w=%b g=%b a=%0d d=%h expected w=1 g=10 a=%0d",
                         i, o_write, o_grant, o_addr, o_data, 100 + i);
                n_err++;
            end
        end
        tick();
        n_vec++;
        if (o_write !== 1'b0) begin
            $display("FAIL hold_empty: got o_write=%b expected 0", o_write);
            n_err++;
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_src0_write = 1'b1;
            i_src0_addr  = AW'(300 + i);
            i_src0_data  = DW'(i);
            tick();
        end
        // Fifth word arrives on the same edge the full FIFO is popped.
        i_enable    = 1'b1;
        i_src0_addr = AW'(304);
        i_src0_data = DW'(4);
        tick();
        idle_inputs();
        n_vec++;
        if ({o_write, o_addr, o_overflow, o_src0_drops} !== {1'b1, 17'd300, 2'b00, 16'd0}) begin
            $display("FAIL fullpop_first: got w=%b a=%0d ovf=%b d0=%0d expected w=1 a=300 ovf=00 d0=0",
                     o_write, o_addr, o_overflow, o_src0_drops);
            n_err++;
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            n_vec++;
            if ({o_write, o_addr, o_data} !== {1'b1, AW'(300 + i), DW'(i)}) begin
                $display("FAIL fullpop_word%0d: got w=%b a=%0d d=%h expected w=1 a=%0d d=%0d",
                         i, o_write, o_addr, o_data, 300 + i, i);
                n_err++;
            end
        end
        // A strobe from a disabled source is ignored outright.
        i_src_en     = 2'b10;
        i_src0_write = 1'b1;
        i_src0_addr  = AW'(999);
        tick();
        idle_inputs();
        tick();
        n_vec++;
        if ({o_write, o_src0_drops} !== {1'b0, 16'd0}) begin
            $display("FAIL src_disabled: got w=%b d0=%0d expected w=0 d0=0", o_write, o_src0_drops);
            n_err++;
        end
        i_src_en = 2'b11;
    endtask

    task automatic test_clear_drop();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_src0_write = 1'b1;
            i_src0_addr  = AW'(500 + i);
            tick();
        end
        n_vec++;
        if ({o_overflow, o_src0_drops} !== {2'b01, 16'd2}) begin
            $display("FAIL clear_pre: got ovf=%b d0=%0d expected ovf=01 d0=2",
                     o_overflow, o_src0_drops);
            n_err++;
        end
        i_clear_flags = 1'b1;
        tick();
        n_vec++;
        if ({o_overflow, o_src0_drops} !== {2'b01, 16'd1}) begin
            $display("FAIL clear_with_drop: got ovf=%b d0=%0d expected ovf=01 d0=1",
                     o_overflow, o_src0_drops);
            n_err++;
        end
        i_src0_write = 1'b0;
        tick();
        n_vec++;
        if ({o_overflow, o_src0_drops} !== {2'b00, 16'd0}) begin
            $display("FAIL clear_only: got ovf=%b d0=%0d expected ovf=00 d0=0",
                     o_overflow, o_src0_drops);
            n_err++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_src0_write = 1'b1;
            i_src0_addr  = AW'(40 + i);
            tick();
        end
        idle_inputs();
        i_enable = 1'b1;
        @(posedge clk);
        #2;
        n_vec++;
        if ({o_write, o_addr} !== {1'b1, 17'd40}) begin
            $display("FAIL midop_active: got w=%b a=%0d expected w=1 a=40", o_write, o_addr);
            n_err++;
        end
        #1 i_reset = 1'b1;
        #1;
        n_vec++;
        if ({o_write, o_grant} !== 3'b000) begin
            $display("FAIL midop_async: got w=%b g=%b expected w=0 g=00", o_write, o_grant);
            n_err++;
        end
        tick();
        i_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (o_write !== 1'b0) begin
                $display("FAIL midop_stale%0d: got o_write=%b a=%0d expected 0", i, o_write, o_addr);
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int          last_addr [2];
        int          writes [2];
        logic [1:0]  prev_grant;
        int          s;
        int          idx;
        logic [DW-1:0] exp_data;
        do_reset();
        last_addr[0] = -1;
        last_addr[1] = -1;
        writes[0]    = 0;
        writes[1]    = 0;
        prev_grant   = 2'b00;
        for (int c = 0; c < 120; c++) begin
            i_src0_write = (c < 100);
            i_src1_write = (c < 100);
            i_src0_addr  = AW'(1000 + c);
            i_src0_data  = DW'(c);
            i_src1_addr  = AW'(2000 + c);
            i_src1_data  = DW'(12'h800 | c);
            tick();
            if (o_write) begin
                n_vec++;
                if (o_grant !== 2'b01 && o_grant !== 2'b10) begin
                    $display("FAIL stream_onehot c=%0d: got g=%b expected 01 or 10", c, o_grant);
                    n_err++;
                end else begin
                    s        = o_grant[1] ? 1 : 0;
                    idx      = int'(o_addr) - (s == 1 ? 2000 : 1000);
                    exp_data = (s == 1) ? DW'(12'h800 | idx) : DW'(idx);
                    n_vec++;
                    if (int'(o_addr) <= last_addr[s] || idx < 0 || idx > 99) begin
                        $display("FAIL stream_order c=%0d: got a=%0d after %0d expected larger in range",
                                 c, o_addr, last_addr[s]);
                        n_err++;
                    end
                    n_vec++;
                    if (o_data !== exp_data) begin
                        $display("FAIL stream_data c=%0d: got d=%h expected %h", c, o_data, exp_data);
                        n_err++;
                    end
                    if (prev_grant != 2'b00) begin
                        n_vec++;
                        if (o_grant === prev_grant) begin
                            $display("FAIL stream_alternate c=%0d: got g=%b twice expected flip",
                                     c, o_grant);
                            n_err++;
                        end
                    end
                    last_addr[s] = int'(o_addr);
                    writes[s]++;
                end
                prev_grant = o_grant;
            end else begin
                prev_grant = 2'b00;
            end
        end
        idle_inputs();
        n_vec++;
        if (writes[0] != 54 || writes[1] != 53) begin
            $display("FAIL stream_writes: got w0=%0d w1=%0d expected w0=54 w1=53",
                     writes[0], writes[1]);
            n_err++;
        end
        n_vec++;
        if ({o_overflow, o_src0_drops, o_src1_drops} !== {2'b11, 16'd46, 16'd47}) begin
            $display("FAIL stream_drops: got ovf=%b d0=%0d d1=%0d expected ovf=11 d0=46 d1=47",
                     o_overflow, o_src0_drops, o_src1_drops);
            n_err++;
        end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_src_en = 2'b11;
        idle_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_enable_hold();
        test_full_pop();
        test_clear_drop();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
